// File: rtl/hdr_sched_pkg.sv
// Shared types and helpers for the AXI-Stream header scheduler: FSM states,
// default sizing constants and the keep-to-byte-count conversion.
package hdr_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OFFER    = 2'd1,
        WAIT_EOP = 2'd2
    } state_e;

    localparam int DEF_N_REQ       = 4;
    localparam int DEF_TIMEOUT_CYC = 1024;
    localparam int GNT_W           = $clog2(DEF_N_REQ);
    localparam int TMO_CNT_W       = $clog2(DEF_TIMEOUT_CYC);
    localparam int KEEP_MAX_W      = 64;

    // A full beat (all keep bits set) wraps to 0, matching the inserter's count encoding.
    function automatic int popcnt_mod(input logic [KEEP_MAX_W-1:0] keep, input int nbytes);
        int cnt;
        cnt = 0;
        for (int i = 0; i < KEEP_MAX_W; i++) begin
            if (i < nbytes && keep[i]) cnt++;
        end
        return cnt % nbytes;
    endfunction

endpackage

// File: rtl/axis_hdr_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request strictly after the
// pointer position, wrapping around; returns one-hot grant and its index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int GW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [GW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [GW-1:0]    gnt_idx,
    output logic             any
);

    logic [GW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = GW'((int'(ptr) + k) % N_REQ);
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/axis_hdr_scheduler.sv
// Round-robin header scheduler for the AXI-Stream header inserter: one header per packet.
// Optional EOP watchdog enabled by defining HDR_SCHED_TIMEOUT_EN.
module axis_hdr_scheduler
    import hdr_sched_pkg::*;
#(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter int N_REQ        = DEF_N_REQ,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_REQ-1:0]                req_valid,
    input  logic [N_REQ*DATA_WD-1:0]        req_data,
    input  logic [N_REQ*DATA_BYTE_WD-1:0]   req_keep,
    output logic [N_REQ-1:0]                req_ready,
    output logic                            valid_insert,
    output logic [DATA_WD-1:0]              data_insert,
    output logic [DATA_BYTE_WD-1:0]         keep_insert,
    output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
    input  logic                            ready_insert,
    input  logic                            valid_out,
    input  logic                            ready_out,
    input  logic                            last_out,
    output logic [$clog2(N_REQ)-1:0]        grant_id,
    output logic                            busy,
    output logic                            err_hdr,
    output logic                            timeout
);

    localparam int GW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT_CYC);

    state_e                  state_q, state_d;
    logic [GW-1:0]           ptr_q, ptr_d;
    logic [GW-1:0]           gid_q, gid_d;
    logic [DATA_WD-1:0]      data_q, data_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic [BYTE_CNT_WD-1:0]  bcnt_q, bcnt_d;
    logic                    err_q, err_d;

    logic [N_REQ-1:0]        arb_gnt;
    logic [N_REQ-1:0]        req_ready_c;
    logic [GW-1:0]           arb_idx;
    logic                    arb_any;
    logic [DATA_WD-1:0]      g_data;
    logic [DATA_BYTE_WD-1:0] g_keep;
    logic                    eop;
    logic                    tmo_hit;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .GW    (GW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    always_comb begin
        g_data = '0;
        g_keep = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                g_data = req_data[i*DATA_WD +: DATA_WD];
                g_keep = req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
            end
        end
    end

    assign eop = valid_out & ready_out & last_out;

`ifdef HDR_SCHED_TIMEOUT_EN
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          tmo_q;

    // Counter idles at zero outside WAIT_EOP, so every entry starts a fresh count.
    always_comb begin
        tcnt_d = '0;
        if (state_q == WAIT_EOP && !eop) tcnt_d = tcnt_q + 1'b1;
    end

    assign tmo_hit = (state_q == WAIT_EOP) && !eop && (tcnt_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            tmo_q  <= tmo_hit;
        end
    end

    assign timeout = tmo_q;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = ^TW'(TIMEOUT_CYC - 1);
    assign tmo_hit        = 1'b0;
    assign timeout        = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gid_d       = gid_q;
        data_d      = data_q;
        keep_d      = keep_q;
        bcnt_d      = bcnt_q;
        err_d       = 1'b0;
        req_ready_c = '0;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready_c = arb_gnt;
                    ptr_d       = arb_idx;
                    // Empty headers are drained so a faulty source cannot stall the ring.
                    if (g_keep == '0) begin
                        err_d = 1'b1;
                    end else begin
                        data_d  = g_data;
                        keep_d  = g_keep;
                        bcnt_d  = BYTE_CNT_WD'(popcnt_mod(KEEP_MAX_W'(g_keep), DATA_BYTE_WD));
                        gid_d   = arb_idx;
                        state_d = OFFER;
                    end
                end
            end
            OFFER: begin
                if (ready_insert) state_d = WAIT_EOP;
            end
            WAIT_EOP: begin
                if (eop || tmo_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= GW'(N_REQ - 1);
            gid_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            bcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            bcnt_q  <= bcnt_d;
            err_q   <= err_d;
        end
    end

    // Grant is combinational from IDLE; masking with rst_n keeps it quiet while reset is held.
    assign req_ready       = req_ready_c & {N_REQ{rst_n}};
    assign valid_insert    = (state_q == OFFER);
    assign busy            = (state_q != IDLE);
    assign data_insert     = data_q;
    assign keep_insert     = keep_q;
    assign byte_insert_cnt = bcnt_q;
    assign grant_id        = gid_q;
    assign err_hdr         = err_q;

endmodule
